// File: rtl/dmem_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_obi_pkg
// Brief    : Shared types and constants for the data-memory OBI responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_obi_pkg;

    localparam int unsigned PKG_DATA_W = 32;
    localparam int unsigned BE_W       = PKG_DATA_W / 8;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] rdata;
        logic                  err;
    } resp_t;

    // Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_delay.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_delay
// Brief    : Fixed-latency shift register carrying {valid, resp_t}.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp_delay
    import dmem_obi_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid_i,
    input  resp_t in_resp_i,
    output logic  out_valid_o,
    output resp_t out_resp_o
);

    logic [LATENCY-1:0] r_valid_q;
    logic [LATENCY-1:0] w_valid_d;
    resp_t              r_resp_q [LATENCY];
    resp_t              w_resp_d [LATENCY];

    always_comb begin
        w_valid_d    = '0;
        w_valid_d[0] = in_valid_i;
        for (int i = 0; i < LATENCY; i++) begin
            w_resp_d[i] = '0;
        end
        w_resp_d[0] = in_resp_i;
        for (int i = 1; i < LATENCY; i++) begin
            w_valid_d[i] = r_valid_q[i-1];
            w_resp_d[i]  = r_resp_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_resp_q[i] <= '0;
            end
        end else begin
            r_valid_q <= w_valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                r_resp_q[i] <= w_resp_d[i];
            end
        end
    end

    assign out_valid_o = r_valid_q[LATENCY-1];
    assign out_resp_o  = r_resp_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/dmem_obi_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_obi_responder
// Brief    : req/gnt/rvalid responder in front of a byte-enabled word RAM,
//            in-order responses with fixed latency. Optional random grant
//            stall enabled by defining DMEM_OBI_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_obi_responder
    import dmem_obi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = PKG_DATA_W,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DEPTH_WORDS     = 256,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o
);

    localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [WIDX_W-1:0] w_word_idx;
    logic [MEM_AW-1:0] w_mem_idx;
    logic              w_err;
    logic              w_accept;
    logic              w_stall_ok;
    logic              w_dly_valid;
    resp_t             w_resp;
    resp_t             w_dly_resp;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [CNT_W-1:0]  w_cnt_d;

    assign w_word_idx = data_addr_i[ADDR_WIDTH-1:2];
    assign w_mem_idx  = w_word_idx[MEM_AW-1:0];
    assign w_err      = (w_word_idx >= WIDX_W'(DEPTH_WORDS)) || (data_addr_i[1:0] != 2'b00);

`ifdef DMEM_OBI_STALL_EN
    logic [7:0] r_lfsr_q;
    logic [7:0] w_lfsr_d;

    always_comb begin
        w_lfsr_d = lfsr_next(r_lfsr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr_q <= LFSR_SEED;
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end

    assign w_stall_ok = (r_lfsr_q[1:0] != 2'b00);
`else
    assign w_stall_ok = 1'b1;
`endif

    // A slot retiring this cycle may be reused by a same-cycle accept.
    assign data_gnt_o = !rst && ((r_cnt_q < CNT_W'(MAX_OUTSTANDING)) || data_rvalid_o) && w_stall_ok;
    assign w_accept   = data_req_i && data_gnt_o;

    always_comb begin
        w_resp.err   = w_err;
        w_resp.rdata = (!data_we_i && !w_err) ? r_mem[w_mem_idx] : '0;
    end

    // RAM is deliberately left out of reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_accept && data_we_i && !w_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be_i[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    dmem_resp_delay #(
        .LATENCY (RESP_LATENCY)
    ) u_resp_delay (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (w_accept),
        .in_resp_i   (w_resp),
        .out_valid_o (w_dly_valid),
        .out_resp_o  (w_dly_resp)
    );

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (w_accept && !w_dly_valid) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end else if (!w_accept && w_dly_valid) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign data_rvalid_o = w_dly_valid;
    assign data_rdata_o  = w_dly_valid ? w_dly_resp.rdata : '0;
    assign data_err_o    = w_dly_valid ? w_dly_resp.err : 1'b0;

`ifndef SYNTHESIS
    a_no_rvalid_when_idle: assert property (@(posedge clk) disable iff (rst)
        !(data_rvalid_o && (r_cnt_q == '0)));
    a_no_gnt_in_reset: assert property (@(posedge clk) rst |-> !data_gnt_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_obi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_obi_responder
// Brief    : Self-checking bench: transaction-level reference model plus
//            directed scenarios. Honours DMEM_OBI_STALL_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_obi_responder;

    localparam int unsigned LAT = 2;
    localparam int unsigned MAXO = 2;

    logic        clk;
    logic        rst;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    int checks = 0;
    int errors = 0;

    dmem_obi_responder #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .DEPTH_WORDS     (256),
        .RESP_LATENCY    (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } pend_t;

    logic [31:0] ref_mem [256];
    pend_t       pend_q[$];
    int unsigned cyc = 0;
    logic [7:0]  lfsr = 8'hA5;
    logic [31:0] got_q[$];
    int          rv_seen = 0;
    int          stall_cycles = 0;
    int          run_cycles = 0;

    function automatic logic stall_ok();
`ifdef DMEM_OBI_STALL_EN
        return lfsr[1:0] != 2'b00;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic model_rvalid();
        return (pend_q.size() > 0) && (pend_q[0].due == cyc);
    endfunction

    function automatic logic model_gnt();
        return ((pend_q.size() < MAXO) || model_rvalid()) && stall_ok();
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q.delete();
            lfsr = 8'hA5;
        end else begin
            logic  rv;
            logic  bad;
            int    idx;
            pend_t p;
            rv = model_rvalid();
            if (data_req_i && model_gnt()) begin
                idx = int'(data_addr_i >> 2);
                bad = (idx >= 256) || (data_addr_i[1:0] != 2'b00);
                p.due = cyc + LAT;
                p.err = bad;
                p.rdata = 32'h0;
                if (!bad && data_we_i) begin
                    for (int b = 0; b < 4; b++)
                        if (data_be_i[b]) ref_mem[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
                end else if (!bad) begin
                    p.rdata = ref_mem[idx];
                end
                pend_q.push_back(p);
            end
            if (rv) void'(pend_q.pop_front());
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("gnt_in_rst", {31'b0, data_gnt_o}, 32'd0);
            chk("rvalid_in_rst", {31'b0, data_rvalid_o}, 32'd0);
            chk("rdata_in_rst", data_rdata_o, 32'd0);
            chk("err_in_rst", {31'b0, data_err_o}, 32'd0);
        end else begin
            logic exp_rv;
            exp_rv = model_rvalid();
            run_cycles++;
            if (!model_gnt()) stall_cycles++;
            chk("gnt", {31'b0, data_gnt_o}, {31'b0, model_gnt()});
            chk("rvalid", {31'b0, data_rvalid_o}, {31'b0, exp_rv});
            if (data_rvalid_o) rv_seen++;
            if (exp_rv) begin
                chk("rdata", data_rdata_o, pend_q[0].rdata);
                chk("err", {31'b0, data_err_o}, {31'b0, pend_q[0].err});
                got_q.push_back(data_rdata_o);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        n = 0;
        @(negedge clk);
        while (!data_gnt_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("gnt_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        data_req_i = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!data_rvalid_o && lat < 20);
        if (!data_rvalid_o) chk("rvalid_timeout", 32'd1, 32'd0);
        rd = data_rdata_o;
        er = data_err_o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string name, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        issue(1'b1, be, addr, wdata);
        wait_resp(rd, er, lat);
        chk({name, "_err"}, {31'b0, er}, {31'b0, exp_err});
        chk({name, "_rdata"}, rd, 32'd0);
    endtask

    task automatic do_read(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        issue(1'b0, 4'h0, addr, 32'h0);
        wait_resp(rd, er, lat);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, {31'b0, er}, {31'b0, exp_err});
    endtask

    task automatic burst(input int cnt, input logic [31:0] base, output int k, output int n);
        logic acc;
        k = 0;
        n = 0;
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_be_i   = 4'h0;
        data_addr_i = base;
        while (k < cnt && n < 100) begin
            @(negedge clk);
            acc = data_gnt_o;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                data_addr_i = base + 32'(k * 4);
            end
            n++;
        end
        data_req_i = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          k;
        int          n;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        int          r;

        rst          = 1'b0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", {31'b0, data_gnt_o}, 32'd0);
        chk("reset_rvalid", {31'b0, data_rvalid_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++)
            issue(1'b1, 4'hF, 32'(i * 4), 32'h1000_0000 + 32'(i * 'h11));
        drain();

        // Full write then read back; latency measured from the accept edge.
        do_write("t1_wr", 4'hF, 32'h88, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 4'h0, 32'h88, 32'h0);
        wait_resp(rd, er, lat);
        chk("t1_latency", 32'(lat), 32'(LAT));
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_err", {31'b0, er}, 32'd0);

        // Partial byte-enable merge.
        do_write("t2_init", 4'hF, 32'h88, 32'h1122_3344, 1'b0);
        do_write("t2_wr", 4'b0101, 32'h88, 32'hAABB_CCDD, 1'b0);
        do_read("t2_rd", 32'h88, 32'h11BB_33DD, 1'b0);
        do_write("be0_wr", 4'h0, 32'h88, 32'hFFFF_FFFF, 1'b0);
        do_read("be0_rd", 32'h88, 32'h11BB_33DD, 1'b0);

        // Error cases never touch the RAM.
        do_write("t3_init", 4'hF, 32'h84, 32'h5566_7788, 1'b0);
        do_read("t3_oob", 32'h400, 32'h0, 1'b1);
        do_read("t3_mis", 32'h86, 32'h0, 1'b1);
        do_write("t3_wr_mis", 4'hF, 32'h86, 32'hFFFF_FFFF, 1'b1);
        do_write("t3_wr_oob", 4'hF, 32'h400, 32'hFFFF_FFFF, 1'b1);
        do_read("t3_keep", 32'h84, 32'h5566_7788, 1'b0);
        do_read("t3_keep0", 32'h0, 32'h1000_0000, 1'b0);

        // Six back-to-back reads with req held.
        got_q.delete();
        burst(6, 32'h0, k, n);
        drain();
        chk("t4_accepts", 32'(k), 32'd6);
`ifndef DMEM_OBI_STALL_EN
        chk("t4_cycles", 32'(n), 32'd6);
`endif
        chk("t4_resp_count", 32'(got_q.size()), 32'd6);
        if (got_q.size() == 6) begin
            chk("t4_first", got_q[0], 32'h1000_0000);
            chk("t4_third", got_q[2], 32'h1000_0022);
            chk("t4_last", got_q[5], 32'h1000_0055);
        end

        // Reset with two reads in flight.
        do_write("t5_wr", 4'hF, 32'h8C, 32'hCAFE_F00D, 1'b0);
        burst(2, 32'h10, k, n);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_gnt_rst", {31'b0, data_gnt_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        rv_seen = 0;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_no_rvalid", 32'(rv_seen), 32'd0);
        do_read("t5_rd", 32'h8C, 32'hCAFE_F00D, 1'b0);

        // Random traffic; checked cycle-by-cycle against the model.
        stall_cycles = 0;
        run_cycles   = 0;
        for (int i = 0; i < 100; i++) begin
            r  = int'($urandom_range(0, 19));
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            if (r < 16)      addr = 32'(r * 4);
            else if (r < 18) addr = 32'h400 + 32'(r * 4);
            else             addr = 32'(r * 4) + 32'd2;
            issue(we, be, addr, $urandom);
        end
        drain();
`ifdef DMEM_OBI_STALL_EN
        $display("info: grant low %0d of %0d cycles", stall_cycles, run_cycles);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
